// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/JUMP/FLUSH with Moore outputs.
// Define SEQ_MEM_TIMEOUT_EN to compile in the MEM-state watchdog that drives o_err.
module cpu_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_instr_valid,
    input  logic [3:0]  i_opcode,
    input  logic        i_mem_ack,
    output logic        o_instr_ready,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_reg_we,
    output logic        o_imm_sel,
    output logic [1:0]  o_alufunc,
    output logic        o_pc_en,
    output logic        o_pc_load,
    output logic        o_flush,
    output logic        o_busy,
    output logic [15:0] o_retired,
    output logic        o_err
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_JUMP   = 3'd5;
    localparam logic [2:0] S_FLUSH  = 3'd6;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
        $error("FLUSH_CYCLES out of range 1-7");
    end
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("MEM_TIMEOUT out of range 1-255");
    end

    logic [2:0]  state_q, state_d;
    logic [3:0]  op_q;
    logic [2:0]  flush_cnt_q;
    logic [15:0] retired_q;
    logic        mem_timeout;
    logic [1:0]  cls;

    assign cls = op_q[3:2];

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam logic [7:0] MEM_LIMIT = 8'(MEM_TIMEOUT - 1);
    logic [7:0] mem_cnt_q;
    logic       err_q;

    // A same-cycle ack takes priority over the limit, so the error is never raised then.
    assign mem_timeout = (state_q == S_MEM) && !i_mem_ack && (mem_cnt_q == MEM_LIMIT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_cnt_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == S_MEM && !i_mem_ack && !mem_timeout)
                mem_cnt_q <= mem_cnt_q + 8'd1;
            else
                mem_cnt_q <= 8'd0;
            if (mem_timeout)
                err_q <= 1'b1;
        end
    end
    assign o_err = err_q;
`else
    assign mem_timeout = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (i_instr_valid) state_d = S_DECODE;
            S_DECODE: begin
                case (i_opcode_class(op_q))
                    2'b00:   state_d = S_MEM;
                    2'b11:   state_d = S_JUMP;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC:   state_d = S_WB;
            S_MEM:    if (i_mem_ack || mem_timeout) state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_JUMP:   state_d = S_FLUSH;
            S_FLUSH:  if (flush_cnt_q == 3'd0) state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    function automatic logic [1:0] i_opcode_class(input logic [3:0] op);
        return op[3:2];
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_FETCH;
            op_q        <= 4'd0;
            flush_cnt_q <= 3'd0;
            retired_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && i_instr_valid)
                op_q <= i_opcode;
            // Counter holds the remaining FLUSH cycles after the current one.
            if (state_q == S_JUMP)
                flush_cnt_q <= FLUSH_LOAD;
            else if (state_q == S_FLUSH && flush_cnt_q != 3'd0)
                flush_cnt_q <= flush_cnt_q - 3'd1;
            if (state_q == S_WB || state_q == S_JUMP)
                retired_q <= retired_q + 16'd1;
        end
    end

    assign o_instr_ready = (state_q == S_FETCH);
    assign o_busy        = (state_q != S_FETCH);
    assign o_mem_req     = (state_q == S_MEM);
    assign o_mem_we      = (state_q == S_MEM);
    assign o_imm_sel     = (state_q == S_EXEC || state_q == S_WB) && (cls == 2'b10);
    assign o_reg_we      = (state_q == S_WB) && (cls == 2'b01 || cls == 2'b10);
    assign o_pc_en       = (state_q == S_WB);
    assign o_pc_load     = (state_q == S_JUMP);
    assign o_flush       = (state_q == S_JUMP || state_q == S_FLUSH);
    assign o_alufunc     = op_q[1:0];
    assign o_retired     = retired_q;

endmodule
